multicycle_main_control: RTL



---
 rtl/multicycle_main_control.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/multicycle_main_control.sv
// multicycle_main_control: LEGv8 multicycle main control FSM (rev 1.0).
// Moore strobes are registered from the next state; FETCH IRWrite/PCWrite are mem_ready-qualified.
`default_nettype none

module multicycle_main_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [10:0] opcode,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic [1:0]  ALUOp,
  output logic        ALUSrc,
  output logic        Reg2Loc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        UncondBranch,
  output logic        illegal,
  output logic [3:0]  state
);

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_WB_R   = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_WB_LD  = 4'd7,
    S_MEM_WR = 4'd8,
    S_BR_CBZ = 4'd9,
    S_BR_B   = 4'd10,
    S_HALT   = 4'd11
  } state_t;

  state_t      state_q, state_d;
  logic        mem_req_q, alusrc_q, reg2loc_q, memread_q, memwrite_q;
  logic        memtoreg_q, regwrite_q, pccond_q, uncond_q, illegal_q;
  logic        fetch_q, brb_q;
  logic [1:0]  aluop_q;

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:   state_d = start ? S_FETCH : S_IDLE;
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND || opcode == OP_ORR)
          state_d = S_EXEC_R;
        else if (opcode == OP_LDUR || opcode == OP_STUR)
          state_d = S_ADDR;
        else if (opcode[10:3] == OP_CBZ)
          state_d = S_BR_CBZ;
        else if (opcode[10:5] == OP_B)
          state_d = S_BR_B;
        else
          state_d = S_HALT;
      end
      S_EXEC_R: state_d = S_WB_R;
      S_WB_R:   state_d = S_FETCH;
      S_ADDR:   state_d = (opcode == OP_LDUR) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: state_d = mem_ready ? S_WB_LD : S_MEM_RD;
      S_WB_LD:  state_d = S_FETCH;
      S_MEM_WR: state_d = mem_ready ? S_FETCH : S_MEM_WR;
      S_BR_CBZ: state_d = S_FETCH;
      S_BR_B:   state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output registers load the decode of the state being entered, so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mem_req_q  <= 1'b0;
      aluop_q    <= 2'b00;
      alusrc_q   <= 1'b0;
      reg2loc_q  <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      regwrite_q <= 1'b0;
      pccond_q   <= 1'b0;
      uncond_q   <= 1'b0;
      illegal_q  <= 1'b0;
      fetch_q    <= 1'b0;
      brb_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= (state_d == S_FETCH) || (state_d == S_MEM_RD) || (state_d == S_MEM_WR);
      aluop_q    <= ((state_d == S_EXEC_R) || (state_d == S_WB_R)) ? 2'b10 :
                    (state_d == S_BR_CBZ) ? 2'b01 : 2'b00;
      alusrc_q   <= (state_d == S_ADDR) || (state_d == S_MEM_RD) || (state_d == S_MEM_WR);
      reg2loc_q  <= (state_d == S_ADDR) || (state_d == S_MEM_WR) || (state_d == S_BR_CBZ);
      memread_q  <= (state_d == S_MEM_RD);
      memwrite_q <= (state_d == S_MEM_WR);
      memtoreg_q <= (state_d == S_WB_LD);
      regwrite_q <= (state_d == S_WB_R) || (state_d == S_WB_LD);
      pccond_q   <= (state_d == S_BR_CBZ);
      uncond_q   <= (state_d == S_BR_B);
      illegal_q  <= illegal_q || (state_d == S_HALT);
      fetch_q    <= (state_d == S_FETCH);
      brb_q      <= (state_d == S_BR_B);
    end
  end

  assign state        = state_q;
  assign mem_req      = mem_req_q;
  assign ALUOp        = aluop_q;
  assign ALUSrc       = alusrc_q;
  assign Reg2Loc      = reg2loc_q;
  assign MemRead      = memread_q;
  assign MemWrite     = memwrite_q;
  assign MemtoReg     = memtoreg_q;
  assign RegWrite     = regwrite_q;
  assign PCWriteCond  = pccond_q;
  assign UncondBranch = uncond_q;
  assign illegal      = illegal_q;
  assign IRWrite      = fetch_q & mem_ready;
  assign PCWrite      = (fetch_q & mem_ready) | brb_q;

endmodule

`default_nettype wire
